// File: rtl/spi_cmd_regfile_if.sv
// Byte-level link between the SPI byte front-end / host model and the command register file.
interface spi_cmd_regfile_if #(parameter int ADDR_W = 3);
  localparam int NREG = 1 << ADDR_W;
  logic                ss;
  logic                rx_done;
  logic [7:0]          rx_byte;
  logic [7:0]          status_in;
  logic [7:0]          tx_byte;
  logic [8*NREG-1:0]   reg_bus;
  logic                wr_strobe;
  logic [ADDR_W-1:0]   wr_addr;
  logic                err;

  modport master (output ss, rx_done, rx_byte, status_in,
                  input  tx_byte, reg_bus, wr_strobe, wr_addr, err);
  modport slave  (input  ss, rx_done, rx_byte, status_in,
                  output tx_byte, reg_bus, wr_strobe, wr_addr, err);
endinterface

// File: rtl/spi_cmd_regfile.sv
// Framed command/address + data parser with a small 8-bit register bank behind spi_slave.
// Define SPI_CMD_AUTOINC_EN for burst access (address advances after each data byte).
module spi_cmd_regfile #(
  parameter int         ADDR_W  = 3,
  parameter logic [7:0] IDLE_TX = 8'hA5
) (
  input logic clk,
  input logic rst,
  spi_cmd_regfile_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                   state;
  logic [7:0]               regs [NREG];
  logic [NREG-1:0][7:0]     view;
  logic                     rx_done_q, ss_q, stb_r, ss_r, cmd_wr;
  logic [7:0]               byte_r;
  logic [ADDR_W-1:0]        addr, addr_nxt;
  logic                     strobe;

  assign strobe = bus.rx_done & ~rx_done_q;

`ifdef SPI_CMD_AUTOINC_EN
  assign addr_nxt = addr + 1'b1;
`else
  assign addr_nxt = addr;
`endif

  // Register 0 is the live status input, not storage.
  assign view[0] = bus.status_in;
  for (genvar k = 1; k < NREG; k++) begin : g_view
    assign view[k] = regs[k];
  end
  assign bus.reg_bus = view;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rx_done_q     <= 1'b0;
      ss_q          <= 1'b0;  // low so a reset with ss held low waits for a fresh falling edge
      stb_r         <= 1'b0;
      ss_r          <= 1'b1;
      byte_r        <= 8'h00;
      cmd_wr        <= 1'b0;
      addr          <= '0;
      bus.tx_byte   <= IDLE_TX;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr   <= '0;
      bus.err       <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else begin
      rx_done_q     <= bus.rx_done;
      ss_q          <= bus.ss;
      stb_r         <= strobe;
      ss_r          <= bus.ss;
      bus.wr_strobe <= 1'b0;
      if (strobe) byte_r <= bus.rx_byte;

      case (state)
        IDLE: begin
          if (ss_q && !bus.ss) state <= CMD;
          if (stb_r && ss_r) bus.err <= 1'b1;
        end
        CMD: if (stb_r) begin
          cmd_wr <= byte_r[7];
          addr   <= byte_r[ADDR_W-1:0];
          state  <= DATA;
          if (!byte_r[7]) bus.tx_byte <= view[byte_r[ADDR_W-1:0]];
        end
        DATA: if (stb_r) begin
          addr <= addr_nxt;
          if (cmd_wr) begin
            if (addr == '0) bus.err <= 1'b1;
            else begin
              regs[addr]    <= byte_r;
              bus.wr_strobe <= 1'b1;
              bus.wr_addr   <= addr;
            end
          end else begin
            bus.tx_byte <= view[addr_nxt];
          end
        end
        default: state <= IDLE;
      endcase

      // A byte completing alongside ss rising is handled above; the frame still closes.
      if (bus.ss && state != IDLE) begin
        state       <= IDLE;
        bus.tx_byte <= IDLE_TX;
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed plus randomized frames checked against a frame-level model of the register file.
module tb_spi_cmd_regfile;
`ifdef SPI_CMD_AUTOINC_EN
  localparam int AUTOINC = 1;
`else
  localparam int AUTOINC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_regfile_if #(.ADDR_W(3)) bus ();
  spi_cmd_regfile #(.ADDR_W(3), .IDLE_TX(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  logic [7:0] m_regs [8];
  logic       m_err;
  logic [2:0] m_last;
  int         m_wr;
  logic [7:0] frame_q [$];

  always @(negedge clk) if (bus.wr_strobe === 1'b1) wr_pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_rd(input logic [2:0] a);
    return (a == 3'd0) ? bus.status_in : m_regs[a];
  endfunction

  function automatic logic [63:0] m_bus();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = m_rd(3'(k));
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
    m_err = 1'b0; m_last = 3'd0; m_wr = 0;
  endtask

  // Raises rx_done for one byte and returns 2 clocks after the rising edge.
  task automatic send(input logic [7:0] b);
    bus.rx_done = 1'b0;
    tick(2);
    bus.rx_byte = b;
    bus.rx_done = 1'b1;
    tick(2);
  endtask

  task automatic run_frame(input string tag);
    logic       wr;
    logic [2:0] a;
    int         p0;
    wr = 1'b0; a = 3'd0; p0 = wr_pulses;
    bus.ss = 1'b0;
    tick(2);
    for (int i = 0; i < frame_q.size(); i++) begin
      send(frame_q[i]);
      if (i == 0) begin
        wr = frame_q[0][7];
        a  = frame_q[0][2:0];
      end else begin
        if (wr) begin
          if (a == 3'd0) m_err = 1'b1;
          else begin m_regs[a] = frame_q[i]; m_last = a; m_wr++; end
        end
        a = a + 3'(AUTOINC);
      end
      chk({tag, " reg_bus"}, bus.reg_bus, m_bus());
      chk({tag, " err"}, bus.err, m_err);
      chk({tag, " tx_byte"}, bus.tx_byte, wr ? 8'hA5 : m_rd(a));
    end
    chk({tag, " wr_addr"}, bus.wr_addr, m_last);
    bus.rx_done = 1'b0;
    bus.ss = 1'b1;
    tick(2);
    chk({tag, " tx idle"}, bus.tx_byte, 8'hA5);
    chk({tag, " wr pulses"}, wr_pulses - p0, m_wr);
    m_wr = 0;
  endtask

  initial begin
    int nd;
    bus.ss = 1'b1; bus.rx_done = 1'b0; bus.rx_byte = 8'h00;
    bus.status_in = 8'hC3;
    m_reset();
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset tx", bus.tx_byte, 8'hA5);
    chk("reset bus", bus.reg_bus, {56'h0, 8'hC3});
    chk("reset err", bus.err, 1'b0);
    chk("reset wr_addr", bus.wr_addr, 3'd0);

    frame_q = '{8'h83, 8'h5A};
    run_frame("t2");
    chk("t2 reg3", bus.reg_bus[31:24], 8'h5A);

    frame_q = '{8'h03};
    run_frame("t3");

`ifdef SPI_CMD_AUTOINC_EN
    frame_q = '{8'h86, 8'h11, 8'h22, 8'h33};
    run_frame("t4");
    chk("t4 reg6", bus.reg_bus[55:48], 8'h11);
    chk("t4 reg7", bus.reg_bus[63:56], 8'h22);
    chk("t4 err", bus.err, 1'b1);
`else
    frame_q = '{8'h82, 8'h11, 8'h22};
    run_frame("t5");
    chk("t5 reg2", bus.reg_bus[23:16], 8'h22);
    chk("t5 reg3", bus.reg_bus[31:24], 8'h5A);
`endif

    // Reset mid-frame: the data byte that follows must not land anywhere.
    bus.ss = 1'b0;
    tick(2);
    send(8'h85);
    bus.rx_done = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_reset();
    send(8'h77);
    chk("t6 no write", bus.reg_bus, m_bus());
    chk("t6 err", bus.err, 1'b0);
    bus.rx_done = 1'b0;
    bus.ss = 1'b1;
    tick(2);
    frame_q = '{8'h81, 8'h44};
    run_frame("t6b");
    chk("t6 reg1", bus.reg_bus[15:8], 8'h44);

    for (int f = 0; f < 25; f++) begin
      bus.status_in = 8'($urandom);
      frame_q = {};
      frame_q.push_back(8'($urandom));
      nd = $urandom_range(0, 4);
      for (int j = 0; j < nd; j++) frame_q.push_back(8'($urandom));
      run_frame("rnd");
    end

    // Byte arriving with ss high is dropped and flags an error.
    send(8'h92);
    m_err = 1'b1;
    bus.rx_done = 1'b0;
    tick(1);
    chk("outside err", bus.err, m_err);
    chk("outside bus", bus.reg_bus, m_bus());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
